// File: rtl/mfcc_pkg.sv
// Definitions shared by the MFCC front-end stages (framing, windowing, FFT).
// Holds the framing FSM state type, common size defaults and a parameter-check helper.
package mfcc_pkg;

  localparam int MFCC_DATA_WIDTH = 16;
  localparam int MFCC_FRAME_SIZE = 256;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    HOP  = 2'd2
  } framing_state_t;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/framing.sv
// Overlapping-frame builder: keeps the latest FRAME_SIZE samples in a ring buffer and
// replays them oldest-first every HOP_SIZE new samples, stalling the input while it replays.
module framing
  import mfcc_pkg::*;
#(
  parameter int DATA_WIDTH = MFCC_DATA_WIDTH,
  parameter int FRAME_SIZE = MFCC_FRAME_SIZE,
  parameter int HOP_SIZE   = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic [DATA_WIDTH-1:0] frame_out,
  output logic                  frame_out_valid,
  input  logic                  frame_out_ready,
  output logic                  frame_out_first,
  output logic                  frame_out_last,
  output logic [15:0]           frame_count
);

  localparam int PTR_W = $clog2(FRAME_SIZE);
  localparam logic [PTR_W-1:0] FRAME_LAST = PTR_W'(FRAME_SIZE - 1);
  localparam logic [PTR_W-1:0] HOP_LAST   = PTR_W'(HOP_SIZE - 1);

  if (!is_pow2(FRAME_SIZE) || FRAME_SIZE < 4) begin : g_bad_frame_size
    $error("framing: FRAME_SIZE must be a power of two and at least 4");
  end
  if (HOP_SIZE < 1 || HOP_SIZE > FRAME_SIZE) begin : g_bad_hop_size
    $error("framing: HOP_SIZE must lie in 1..FRAME_SIZE");
  end

  logic [DATA_WIDTH-1:0] buffer [FRAME_SIZE];
  framing_state_t        state;
  logic                  running;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      emit_cnt;
  logic [PTR_W-1:0]      fill_cnt;
  logic [PTR_W-1:0]      hop_cnt;
  logic [15:0]           frame_cnt;
  logic                  in_xfer;
  logic                  out_xfer;

  // running holds sample_ready low while reset is applied and releases it one edge later
  assign sample_ready    = running && (state != EMIT);
  assign frame_out_valid = (state == EMIT);
  assign frame_out       = (state == EMIT) ? buffer[rd_ptr] : '0;
  assign frame_out_first = (state == EMIT) && (emit_cnt == '0);
  assign frame_out_last  = (state == EMIT) && (emit_cnt == FRAME_LAST);
  assign frame_count     = frame_cnt;

  assign in_xfer  = sample_valid && sample_ready;
  assign out_xfer = frame_out_valid && frame_out_ready;

  // Buffer contents survive reset; FILL overwrites every entry before it is read
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      buffer[wr_ptr] <= sample_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      running   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      emit_cnt  <= '0;
      fill_cnt  <= '0;
      hop_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      running <= 1'b1;
      if (in_xfer) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case (state)
        FILL: begin
          if (in_xfer) begin
            if (fill_cnt == FRAME_LAST) begin
              fill_cnt <= '0;
              rd_ptr   <= wr_ptr + 1'b1;
              state    <= EMIT;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_xfer) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (emit_cnt == FRAME_LAST) begin
              emit_cnt  <= '0;
              frame_cnt <= frame_cnt + 1'b1;
              state     <= HOP;
            end else begin
              emit_cnt <= emit_cnt + 1'b1;
            end
          end
        end
        HOP: begin
          // The slot just written is the newest, so the one after it is the oldest sample
          if (in_xfer) begin
            if (hop_cnt == HOP_LAST) begin
              hop_cnt <= '0;
              rd_ptr  <= wr_ptr + 1'b1;
              state   <= EMIT;
            end else begin
              hop_cnt <= hop_cnt + 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_framing.sv
// Self-checking bench for framing: four configurations share one stimulus path, selected by sel,
// with a scoreboard that predicts every emitted frame from the history of accepted samples.
module tb_framing;

  typedef struct packed {
    logic [15:0] data;
    logic        first;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        frame_out_ready;
  logic [1:0]  sel;

  logic        sr  [4];
  logic        fov [4];
  logic        ff  [4];
  logic        fl  [4];
  logic [15:0] fo  [4];
  logic [15:0] fc  [4];

  logic        cur_sr, cur_v, cur_ff, cur_fl;
  logic [15:0] cur_fo, cur_fc;

  int          checks;
  int          failures;
  int          frame_sz;
  int          hop_sz;
  int          acc_cnt;
  logic [15:0] next_val;
  logic [15:0] exp_frames;
  logic [15:0] hist [$];
  exp_t        exp_q [$];

  framing #(.DATA_WIDTH(16), .FRAME_SIZE(8), .HOP_SIZE(4)) u_d0 (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid && sel == 2'd0),
    .sample_ready(sr[0]), .frame_out(fo[0]), .frame_out_valid(fov[0]), .frame_out_ready(frame_out_ready),
    .frame_out_first(ff[0]), .frame_out_last(fl[0]), .frame_count(fc[0]));

  framing #(.DATA_WIDTH(16), .FRAME_SIZE(8), .HOP_SIZE(8)) u_d1 (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid && sel == 2'd1),
    .sample_ready(sr[1]), .frame_out(fo[1]), .frame_out_valid(fov[1]), .frame_out_ready(frame_out_ready),
    .frame_out_first(ff[1]), .frame_out_last(fl[1]), .frame_count(fc[1]));

  framing #(.DATA_WIDTH(16), .FRAME_SIZE(256), .HOP_SIZE(128)) u_d2 (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid && sel == 2'd2),
    .sample_ready(sr[2]), .frame_out(fo[2]), .frame_out_valid(fov[2]), .frame_out_ready(frame_out_ready),
    .frame_out_first(ff[2]), .frame_out_last(fl[2]), .frame_count(fc[2]));

  framing #(.DATA_WIDTH(16), .FRAME_SIZE(4), .HOP_SIZE(1)) u_d3 (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid && sel == 2'd3),
    .sample_ready(sr[3]), .frame_out(fo[3]), .frame_out_valid(fov[3]), .frame_out_ready(frame_out_ready),
    .frame_out_first(ff[3]), .frame_out_last(fl[3]), .frame_count(fc[3]));

  assign cur_sr = sr[sel];
  assign cur_v  = fov[sel];
  assign cur_ff = ff[sel];
  assign cur_fl = fl[sel];
  assign cur_fo = fo[sel];
  assign cur_fc = fc[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_model(input int fsize, input int hsize, input logic [15:0] base);
    frame_sz   = fsize;
    hop_sz     = hsize;
    acc_cnt    = 0;
    next_val   = base;
    exp_frames = '0;
    hist.delete();
    exp_q.delete();
  endtask

  // Once the buffer has filled, every HOP_SIZE-th accepted sample closes a frame
  task automatic model_accept(input logic [15:0] value, output bit completed);
    exp_t e;
    hist.push_back(value);
    if (hist.size() > frame_sz) void'(hist.pop_front());
    acc_cnt++;
    completed = (acc_cnt == frame_sz) ||
                (acc_cnt > frame_sz && ((acc_cnt - frame_sz) % hop_sz) == 0);
    if (completed) begin
      for (int k = 0; k < frame_sz; k++) begin
        e.data  = hist[k];
        e.first = (k == 0);
        e.last  = (k == frame_sz - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic apply_reset(input logic [1:0] which, input int fsize, input int hsize);
    @(negedge clk);
    sel          = which;
    rst          = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_model(fsize, hsize, 16'd0);
  endtask

  task automatic run_stream(input int n_frames, input int valid_pct, input bit toggle_ready,
                            input int stop_frame, input int stop_idx, input int budget);
    int   done = 0;
    int   cyc = 0;
    int   pop_idx = 0;
    bit   expect_rise = 0;
    bit   expect_back = 0;
    bit   held = 0;
    bit   completed;
    bit   in_x;
    bit   out_x;
    logic [15:0] held_data = '0;
    logic held_first = 1'b0;
    logic held_last = 1'b0;
    exp_t e;
    while (done < n_frames) begin
      @(negedge clk);
      sample_valid    = ($urandom_range(99) < valid_pct);
      sample_in       = next_val;
      frame_out_ready = toggle_ready ? ~frame_out_ready : 1'b1;
      #1;
      checks++;
      if (cur_fc !== exp_frames) begin
        failures++;
        $display("[TB] FAIL frame_count: got %0d expected %0d", cur_fc, exp_frames);
      end
      if (expect_rise) begin
        checks++;
        if ({cur_v, cur_ff} !== 2'b11) begin
          failures++;
          $display("[TB] FAIL frame_latency: valid/first got %b expected 11", {cur_v, cur_ff});
        end
      end
      if (expect_back) begin
        checks++;
        if ({cur_sr, cur_v} !== 2'b10) begin
          failures++;
          $display("[TB] FAIL ready_return: ready/valid got %b expected 10", {cur_sr, cur_v});
        end
      end
      if (cur_v === 1'b1) begin
        checks++;
        if (cur_sr !== 1'b0) begin
          failures++;
          $display("[TB] FAIL ready_in_emit: sample_ready got %b expected 0", cur_sr);
        end
      end
      if (held) begin
        checks++;
        if ({cur_v, cur_fo, cur_ff, cur_fl} !== {1'b1, held_data, held_first, held_last}) begin
          failures++;
          $display("[TB] FAIL stall_hold: got v=%b d=%h f=%b l=%b expected v=1 d=%h f=%b l=%b",
                   cur_v, cur_fo, cur_ff, cur_fl, held_data, held_first, held_last);
        end
      end
      if (stop_frame > 0 && done == stop_frame - 1 && pop_idx == stop_idx && cur_v === 1'b1) return;
      expect_rise = 0;
      expect_back = 0;
      in_x       = sample_valid && (cur_sr === 1'b1);
      out_x      = (cur_v === 1'b1) && frame_out_ready;
      held       = (cur_v === 1'b1) && !frame_out_ready;
      held_data  = cur_fo;
      held_first = cur_ff;
      held_last  = cur_fl;
      if (out_x) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_output: got data %h expected no output", cur_fo);
        end else begin
          e = exp_q.pop_front();
          if ({cur_fo, cur_ff, cur_fl} !== {e.data, e.first, e.last}) begin
            failures++;
            $display("[TB] FAIL frame_data[%0d]: got d=%h f=%b l=%b expected d=%h f=%b l=%b",
                     pop_idx, cur_fo, cur_ff, cur_fl, e.data, e.first, e.last);
          end
          if (e.last) begin
            exp_frames++;
            done++;
            pop_idx     = 0;
            expect_back = 1;
          end else begin
            pop_idx++;
          end
        end
      end
      if (in_x) begin
        model_accept(sample_in, completed);
        next_val++;
        if (completed) expect_rise = 1;
      end
      cyc++;
      if (cyc > budget) begin
        checks++;
        failures++;
        $display("[TB] FAIL timeout: got %0d frames expected %0d within %0d cycles", done, n_frames, budget);
        break;
      end
    end
    @(negedge clk);
    sample_valid = 1'b0;
    #1;
    checks++;
    if ({cur_fc, cur_v} !== {exp_frames, 1'b0}) begin
      failures++;
      $display("[TB] FAIL end_state: count/valid got %0d/%b expected %0d/0", cur_fc, cur_v, exp_frames);
    end
  endtask

  task automatic test_reset();
    sel = 2'd0;
    rst = 1'b1;
    #1;
    checks++;
    if ({cur_sr, cur_v, cur_ff, cur_fl, cur_fo, cur_fc} !== 36'd0) begin
      failures++;
      $display("[TB] FAIL reset_values: got sr=%b v=%b f=%b l=%b d=%h c=%0d expected all 0",
               cur_sr, cur_v, cur_ff, cur_fl, cur_fo, cur_fc);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (cur_sr !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_after_reset: got %b expected 1", cur_sr);
    end
  endtask

  task automatic test_ramp();
    apply_reset(2'd0, 8, 4);
    run_stream(3, 100, 1'b0, 0, 0, 500);
  endtask

  task automatic test_backpressure();
    apply_reset(2'd0, 8, 4);
    run_stream(3, 100, 1'b1, 0, 0, 500);
    frame_out_ready = 1'b1;
  endtask

  task automatic test_random_valid();
    apply_reset(2'd2, 256, 128);
    run_stream(2, 50, 1'b0, 0, 0, 5000);
  endtask

  task automatic test_non_overlap();
    apply_reset(2'd1, 8, 8);
    run_stream(2, 100, 1'b0, 0, 0, 500);
  endtask

  task automatic test_reset_mid_frame();
    apply_reset(2'd0, 8, 4);
    run_stream(3, 100, 1'b0, 2, 3, 500);
    rst = 1'b1;
    #1;
    checks++;
    if ({cur_sr, cur_v, cur_ff, cur_fl, cur_fo, cur_fc} !== 36'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset_values: got sr=%b v=%b f=%b l=%b d=%h c=%0d expected all 0",
               cur_sr, cur_v, cur_ff, cur_fl, cur_fo, cur_fc);
    end
    sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_model(8, 4, 16'd100);
    run_stream(1, 100, 1'b0, 0, 0, 500);
  endtask

  task automatic test_count_wrap();
    apply_reset(2'd3, 4, 1);
    run_stream(1, 100, 1'b0, 0, 0, 200);
    force u_d3.frame_cnt = 16'hFFFF;
    #1;
    release u_d3.frame_cnt;
    exp_frames = 16'hFFFF;
    run_stream(2, 100, 1'b0, 0, 0, 200);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    sample_in       = '0;
    sample_valid    = 1'b0;
    frame_out_ready = 1'b1;
    clear_model(8, 4, 16'd0);
    test_reset();
    test_ramp();
    test_backpressure();
    test_random_valid();
    test_non_overlap();
    test_reset_mid_frame();
    test_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/framing.md
# framing

Overlapping-frame builder at the front of the MFCC pipeline: accepts a serial stream of pre-emphasised audio samples, holds the most recent FRAME_SIZE samples in a ring buffer, and emits each frame serially (oldest sample first) to the windowing stage every HOP_SIZE new samples. Back-pressure is applied upstream while a frame is being emitted, so no sample is dropped or overwritten. The first frame is emitted only once the buffer has filled.

## Interface

- DATA_WIDTH, 16, sample width (two's complement, passed through unmodified)
- FRAME_SIZE, 256, samples per frame; power of two, ≥ 4
- HOP_SIZE, 128, new samples between successive frames; 1 ≤ HOP_SIZE ≤ FRAME_SIZE

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- sample_in  in  DATA_WIDTH  input sample
- sample_valid  in  1  sample_in valid
- sample_ready  out  1  block accepts sample this cycle
- frame_out  out  DATA_WIDTH  frame sample, oldest first
- frame_out_valid  out  1  frame_out valid
- frame_out_ready  in  1  downstream accepts frame_out
- frame_out_first  out  1  frame_out is sample 0 of a frame
- frame_out_last  out  1  frame_out is sample FRAME_SIZE-1
- frame_count  out  16  frames completed, wraps 0xFFFF→0

## Operation

- Ring buffer: FRAME_SIZE × DATA_WIDTH register array; wr_ptr (log2 FRAME_SIZE bits) wraps naturally.
- Input transfer = sample_valid & sample_ready: write buf[wr_ptr], wr_ptr+1.
- Output transfer = frame_out_valid & frame_out_ready: rd_ptr+1, emit_cnt+1.
- States:
  - FILL: sample_ready=1; fill_cnt counts transfers; on the FRAME_SIZE-th transfer → EMIT, rd_ptr ← wr_ptr after the write (= oldest sample).
  - EMIT: sample_ready=0; frame_out_valid=1; frame_out=buf[rd_ptr]; first = (emit_cnt==0), last = (emit_cnt==FRAME_SIZE-1). On last transfer: frame_count+1, emit_cnt←0, → HOP.
  - HOP: sample_ready=1; hop_cnt counts transfers; on the HOP_SIZE-th → EMIT, rd_ptr ← wr_ptr after the write.
- Outputs are functions of registered state/pointers only; sample_ready never depends on sample_valid, frame_out_valid never depends on frame_out_ready.
- frame_out, first, last stable while valid & !ready.
- HOP_SIZE == FRAME_SIZE: non-overlapping frames, HOP identical to a full refill.
- Samples are not altered; no saturation or width change.

## Timing

- Reset values: sample_ready=0 during reset, 1 from first cycle after deassertion (state FILL); frame_out_valid=0, frame_out_first=0, frame_out_last=0, frame_out=0, frame_count=0; all pointers/counters 0.
- Latency: frame_out_valid rises the cycle after the completing input transfer; frame_out_first=1 that cycle.
- With frame_out_ready held 1: one frame = FRAME_SIZE cycles; sample_ready returns 1 the cycle after the last transfer.
- Steady state (no stalls): period = HOP_SIZE + FRAME_SIZE cycles per frame.
- Stalls: sample_valid=0 in FILL/HOP or frame_out_ready=0 in EMIT freeze progress, no data loss.
- Reset mid-operation (any state): immediate return to reset values; partial frame discarded; buffer contents not cleared (don't-care, overwritten by FILL before use).
- frame_count wraps 0xFFFF→0 silently.

## Structure

- Shared package mfcc_pkg: framing_state_t enum {FILL, EMIT, HOP}; common DATA_WIDTH/FRAME_SIZE defaults used by windowing and FFT stages.
- No sub-module: buffer, FSM and counters live in one module (≈150-250 lines).
- Parameter checks (HOP_SIZE range, FRAME_SIZE power of two) as elaboration-time assertions.

## Test plan

- FRAME_SIZE=8, HOP_SIZE=4, ramp 0,1,2,… continuous, ready=1 -> frames 0..7, 4..11, 8..15; first on 0/4/8, last on 7/11/15; frame_count 1,2,3.
- Same, frame_out_ready toggled 1/0 every cycle -> identical sequence, frame_out held during low ready, sample_ready=0 throughout EMIT.
- sample_valid random 50%, defaults 256/128 -> first frame = samples 0..255, second = 128..383, no gaps or duplicates.
- HOP_SIZE=FRAME_SIZE=8 -> frames 0..7, 8..15 non-overlapping.
- rst asserted at emit_cnt=3 of frame 2 -> all outputs to reset values next edge; after release, 8 new samples 100..107 -> frame 100..107, frame_count=1.
- Force frame_count=0xFFFF via 65535 frames (FRAME_SIZE=4, HOP_SIZE=1) -> next frame completion wraps it to 0.
